// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder/subtractor.
//   NIBBLE       : width of one arithmetic slice (4 bits)
//   nsa_state_t  : control FSM encoding (IDLE, RUN, DONE)
package adder_pkg;

  localparam int NIBBLE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } nsa_state_t;

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle for nibble_serial_adder.
//   master : operand source and result consumer (drives in_valid, a, b, cin,
//            sub, out_ready; observes in_ready, out_valid, sum, cout, ovf)
//   slave  : the adder itself (the mirror image)
interface nibble_serial_adder_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/nibble_serial_adder_slice.sv
// adder_1a: 4-bit ripple-carry adder slice, purely combinational.
//   a_i, b_i : 4-bit addends
//   cin_i    : carry into bit 0
//   sum_o    : 4-bit sum
//   cout_o   : carry out of bit 3
module adder_1a (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] sum_o,
  output logic       cout_o
);

  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, cin_i};

endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit adder/subtractor that pushes one nibble per
// clock through a single 4-bit adder_1a slice, least significant nibble
// first, with a registered carry linking the nibbles.
//   clk, rst  : rising-edge clock, synchronous active-high reset
//   bus.slave : in_valid/in_ready operand handshake (a, b, cin, sub) and
//               out_valid/out_ready result handshake (sum, cout, ovf)
// A result appears exactly WIDTH/4 edges after the operand is accepted and
// holds until the consumer takes it; there is no overlap between operations.
module nibble_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  nibble_serial_adder_if.slave bus
);

  localparam int NNIB = WIDTH / NIBBLE;
  localparam int IDXW = (NNIB > 1) ? $clog2(NNIB) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NNIB - 1);

  generate
    if ((WIDTH % NIBBLE) != 0 || WIDTH < NIBBLE) begin : g_bad_width
      $error("nibble_serial_adder: WIDTH must be a positive multiple of 4");
    end
  endgenerate

  nsa_state_t       state_q;
  logic [IDXW-1:0]  idx_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  logic [NIBBLE-1:0] a_nib;
  logic [NIBBLE-1:0] b_nib;
  logic [NIBBLE-1:0] nib_sum;
  logic              nib_cout;
  logic              ovf_d;

  // Handshake flags come straight from the registered state.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

  assign a_nib = a_q[NIBBLE*idx_q +: NIBBLE];
  assign b_nib = b_q[NIBBLE*idx_q +: NIBBLE];

  adder_1a u_slice (
    .a_i    (a_nib),
    .b_i    (b_nib),
    .cin_i  (carry_q),
    .sum_o  (nib_sum),
    .cout_o (nib_cout)
  );

  // Only meaningful on the top nibble. b_q already holds ~b for subtract, so
  // the usual same-sign-in / different-sign-out rule covers both operations.
  assign ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                 (nib_sum[NIBBLE-1] != a_q[WIDTH-1]);

  // Operand capture: loaded only on the accepting edge, so later changes on
  // the bus have no effect on the running operation.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && bus.in_valid) begin
      a_q <= bus.a;
      b_q <= bus.sub ? ~bus.b : bus.b;
    end
  end

  // Control FSM with index counter, carry link and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            // Subtract is a + ~b + 1: the +1 enters as the initial carry.
            carry_q <= bus.sub ? 1'b1 : bus.cin;
            idx_q   <= '0;
            sum_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q[NIBBLE*idx_q +: NIBBLE] <= nib_sum;
          carry_q                       <= nib_cout;
          if (idx_q == LAST_IDX) begin
            idx_q   <= '0;
            cout_q  <= nib_cout;
            ovf_q   <= ovf_d;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + IDXW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=16): directed cases with
// hand-computed results, backpressure, mid-operation reset, and randomized
// operations checked against an arithmetic reference model.
module tb_nibble_serial_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  nibble_serial_adder_if #(.WIDTH(16)) bus ();

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, time=%0t limit=300000", $time);
    $fatal(1, "watchdog");
  end

  // Reference: plain integer arithmetic on the operand values.
  function automatic void ref_model(input logic [15:0] a, input logic [15:0] b,
                                    input logic cin, input logic sub,
                                    output logic [15:0] s, output logic co,
                                    output logic ov);
    int ua, ub, sa, sb, u, sr;
    ua = a;
    ub = b;
    sa = $signed(a);
    sb = $signed(b);
    if (sub) begin
      u  = ua - ub;
      co = (ua >= ub);
      sr = sa - sb;
    end else begin
      u  = ua + ub + int'(cin);
      co = (u >= 65536);
      sr = sa + sb + int'(cin);
    end
    s  = 16'(u);
    ov = (sr > 32767) || (sr < -32768);
  endfunction

  // Presents one operand, scrambles the bus after acceptance, and counts
  // edges until out_valid. Leaves the DUT in DONE (result not consumed).
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic sub,
                        output int lat, output bit busy_bad);
    int w;
    w = 0;
    busy_bad = 1'b0;
    lat = -1;
    while (!bus.in_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    bus.a = a; bus.b = b; bus.cin = cin; bus.sub = sub;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a = 16'($urandom); bus.b = 16'($urandom);
    bus.cin = 1'($urandom); bus.sub = 1'($urandom);
    for (int n = 1; n <= 20; n++) begin
      if (bus.in_ready || bus.out_valid) busy_bad = 1'b1;
      @(posedge clk); #1;
      if (bus.out_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
      failures++;
      $display("FAIL reset_flags: in_ready,out_valid=%b required=10", {bus.in_ready, bus.out_valid});
    end
    checks++;
    if ({bus.sum, bus.cout, bus.ovf} !== 18'h0) begin
      failures++;
      $display("FAIL reset_result: sum=%h cout=%b ovf=%b required 0000/0/0", bus.sum, bus.cout, bus.ovf);
    end
  endtask

  task automatic test_directed();
    logic [15:0] ta[7] = '{16'h1234, 16'hFFFF, 16'h000F, 16'h7FFF, 16'h8000, 16'h0005, 16'h0007};
    logic [15:0] tb[7] = '{16'h1111, 16'h0001, 16'h0000, 16'h0001, 16'h0001, 16'h0007, 16'h0005};
    logic        tc[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        tsb[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [15:0] es[7] = '{16'h2345, 16'h0000, 16'h0010, 16'h8000, 16'h7FFF, 16'hFFFE, 16'h0002};
    logic        ec[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic        eo[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    int lat;
    bit busy_bad;
    for (int i = 0; i < 7; i++) begin
      run_op(ta[i], tb[i], tc[i], tsb[i], lat, busy_bad);
      checks++;
      if (lat != 4 || busy_bad) begin
        failures++;
        $display("FAIL directed%0d_latency: lat=%0d busy_bad=%0d required lat=4 busy_bad=0", i, lat, busy_bad);
      end
      checks++;
      if ({bus.sum, bus.cout, bus.ovf} !== {es[i], ec[i], eo[i]}) begin
        failures++;
        $display("FAIL directed%0d_result: sum=%h cout=%b ovf=%b required sum=%h cout=%b ovf=%b",
                 i, bus.sum, bus.cout, bus.ovf, es[i], ec[i], eo[i]);
      end
      drain();
      checks++;
      if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
        failures++;
        $display("FAIL directed%0d_release: in_ready,out_valid=%b required=10", i, {bus.in_ready, bus.out_valid});
      end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] es, es2;
    logic ec, eo, ec2, eo2;
    int lat;
    bit busy_bad;
    ref_model(16'h1234, 16'h0FFF, 1'b0, 1'b0, es, ec, eo);
    run_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, lat, busy_bad);
    checks++;
    if (lat != 4 || busy_bad) begin
      failures++;
      $display("FAIL bp_latency: lat=%0d busy_bad=%0d required lat=4 busy_bad=0", lat, busy_bad);
    end
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = 1'($urandom);
      bus.a = 16'($urandom); bus.b = 16'($urandom);
      @(posedge clk); #1;
      checks++;
      if ({bus.out_valid, bus.in_ready, bus.sum, bus.cout, bus.ovf} !== {2'b10, es, ec, eo}) begin
        failures++;
        $display("FAIL bp_hold%0d: out_valid=%b in_ready=%b sum=%h cout=%b ovf=%b required 1/0/%h/%b/%b",
                 c, bus.out_valid, bus.in_ready, bus.sum, bus.cout, bus.ovf, es, ec, eo);
      end
    end
    // Keep in_valid high across the output handshake: it must not be taken.
    bus.in_valid = 1'b1;
    bus.a = 16'h4321; bus.b = 16'h1234; bus.cin = 1'b1; bus.sub = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.sum} !== {2'b10, es}) begin
      failures++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b sum=%h required 1/0/%h",
               bus.in_ready, bus.out_valid, bus.sum, es);
    end
    ref_model(16'h4321, 16'h1234, 1'b1, 1'b1, es2, ec2, eo2);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_next_accept: in_ready=%b required=0", bus.in_ready);
    end
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (bus.out_valid) begin
        lat = n;
        break;
      end
    end
    checks++;
    if (lat != 4 || {bus.sum, bus.cout, bus.ovf} !== {es2, ec2, eo2}) begin
      failures++;
      $display("FAIL bp_next_result: lat=%0d sum=%h cout=%b ovf=%b required lat=4 %h/%b/%b",
               lat, bus.sum, bus.cout, bus.ovf, es2, ec2, eo2);
    end
    drain();
  endtask

  task automatic test_reset_mid_run();
    logic [15:0] es;
    logic ec, eo;
    int lat;
    bit busy_bad;
    bit seen;
    bus.a = 16'hFFFF; bus.b = 16'h1111; bus.cin = 1'b1; bus.sub = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.sum, bus.cout, bus.ovf} !== {2'b10, 18'h0}) begin
      failures++;
      $display("FAIL midrst_state: in_ready=%b out_valid=%b sum=%h cout=%b ovf=%b required 1/0/0000/0/0",
               bus.in_ready, bus.out_valid, bus.sum, bus.cout, bus.ovf);
    end
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL midrst_no_output: out_valid_seen=1 required=0");
    end
    ref_model(16'h0ABC, 16'h0F0F, 1'b0, 1'b0, es, ec, eo);
    run_op(16'h0ABC, 16'h0F0F, 1'b0, 1'b0, lat, busy_bad);
    checks++;
    if (lat != 4 || {bus.sum, bus.cout, bus.ovf} !== {es, ec, eo}) begin
      failures++;
      $display("FAIL midrst_fresh: lat=%0d sum=%h cout=%b ovf=%b required lat=4 %h/%b/%b",
               lat, bus.sum, bus.cout, bus.ovf, es, ec, eo);
    end
    drain();
  endtask

  task automatic test_random();
    logic [15:0] a, b, es;
    logic cin, sub, ec, eo;
    int lat;
    bit busy_bad;
    int stall;
    for (int i = 0; i < 60; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      case ($urandom_range(0, 5))
        0: a = 16'h7FFF;
        1: b = 16'h8000;
        2: b = a;
        default: ;
      endcase
      cin = 1'($urandom);
      sub = 1'($urandom);
      ref_model(a, b, cin, sub, es, ec, eo);
      run_op(a, b, cin, sub, lat, busy_bad);
      stall = $urandom_range(0, 3);
      repeat (stall) begin
        @(posedge clk); #1;
      end
      checks++;
      if (lat != 4 || busy_bad || bus.out_valid !== 1'b1 ||
          {bus.sum, bus.cout, bus.ovf} !== {es, ec, eo}) begin
        failures++;
        $display("FAIL random%0d a=%h b=%h cin=%b sub=%b: lat=%0d out_valid=%b sum=%h cout=%b ovf=%b required lat=4 1/%h/%b/%b",
                 i, a, b, cin, sub, lat, bus.out_valid, bus.sum, bus.cout, bus.ovf, es, ec, eo);
      end
      drain();
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.sub       = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-cycle wide adder/subtractor that feeds the existing 4-bit ripple-carry slice `adder_1a` one nibble per clock and consumes its sum and carry-out.
- A registered carry links the nibbles, least significant first.
- Operands arrive over a valid/ready handshake; the result leaves over a second valid/ready handshake.
- Sits between the operand source and any result consumer in the datapath.

Parameters:
- WIDTH, 16, operand and result width in bits. Must be a multiple of 4 and at least 4; elaboration fails otherwise.
- NNIB, WIDTH/4, derived nibble count. Localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  operand transfer request
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in for add; ignored when sub=1
- sub  input  1  1 = compute a - b
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result
- cout  output  1  final carry-out; for sub, 1 = no borrow
- ovf  output  1  two's-complement signed overflow

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, nibble index=0, carry register=0.
- Reset has priority over every handshake. Reset mid-RUN or in DONE discards the operation; no out_valid is produced.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - RUN: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- IDLE -> RUN on in_valid && in_ready. On that edge:
  - a_reg <= a
  - b_reg <= sub ? ~b : b
  - carry <= sub ? 1 : cin
  - idx <= 0, sum <= 0, sub_reg <= sub
- RUN, each cycle:
  - `adder_1a` receives a_reg[4*idx+:4], b_reg[4*idx+:4], carry.
  - On the edge, its sum is written to sum[4*idx+:4] and carry <= its cout.
  - idx increments.
  - When idx==NNIB-1, the state moves to DONE on that edge, cout <= final carry, and ovf is registered.
- ovf = (a_reg[W-1]==b_reg[W-1]) && (sum[W-1]!=a_reg[W-1]), computed with the just-produced top nibble.
- Latency: out_valid goes high exactly NNIB clock edges after the accepting edge. With WIDTH=16 this is 4 cycles; with WIDTH=4 it is 1 cycle.
- DONE -> IDLE on out_valid && out_ready. sum, cout and ovf hold stable while out_valid=1 && !out_ready, and keep their values after returning to IDLE until the next accept.
- No overlap: a new operand is accepted at the earliest in the cycle after the output handshake. in_ready is combinational from state only and never depends on out_ready.
- in_valid while not in IDLE is ignored. Operand inputs are sampled only on the accepting edge; later changes have no effect.
- Arithmetic is modulo 2^WIDTH. Subtract is a + ~b + 1; cout=1 means a >= b unsigned.

Decomposition:
- Package adder_pkg:
  - localparam NIBBLE=4
  - typedef enum logic [1:0] {IDLE, RUN, DONE} nsa_state_t
- Sub-module: exactly one instance of the existing `adder_1a` as the per-nibble slice.
- FSM, index counter, carry register and result register stay in nibble_serial_adder.

Test Plan:
All cases use WIDTH=16.
1. a=0x1234, b=0x1111, cin=0, sub=0 -> sum=0x2345, cout=0, ovf=0. out_valid rises exactly 4 edges after accept; in_ready=0 during those cycles.
2. a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0 (carry crosses all 4 nibble boundaries). a=0x000F, b=0x0000, cin=1 -> sum=0x0010.
3. a=0x7FFF, b=0x0001, add -> sum=0x8000, cout=0, ovf=1. a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1.
4. a=0x0005, b=0x0007, sub=1, cin=1 -> sum=0xFFFE, cout=0, ovf=0 (cin ignored). a=0x0007, b=0x0005, sub=1 -> sum=0x0002, cout=1.
5. Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid, sum, cout, ovf constant; in_valid pulses ignored. Then out_ready=1 for 1 cycle -> IDLE, and the next operand is accepted on the following edge.
6. Assert rst during the 2nd RUN cycle -> next cycle in_ready=1, out_valid=0, sum=0, cout=0, ovf=0; out_valid never rises for the aborted operation. A fresh add after reset returns the correct result.
